// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
//   Detects load-use hazards, multicycle-multiply waits and control
//   transfers (taken branch / jump), and drives the stall and flush
//   controls for the F/D/E stages.
//
// Ports
//   clk                    single clock, rising edge
//   reset                  synchronous, active low
//   mem_to_reg_e           instruction in E is a load
//   reg_dst_e              destination register of the E instruction
//   rs_d, rt_d             source registers of the D instruction
//   rs_used_d, rt_used_d   D instruction actually reads rs / rt
//   start_mult             D issues a multicycle multiply this cycle
//   mult_ready             multiplier idle / result available
//   bt_flush, j_flush      taken branch / jump resolved this cycle
//   stall_f, stall_d       hold PC / hold the D register
//   flush_e                insert a bubble into E
//   flush_d                squash the D register
//   stall_cnt, flush_cnt   performance counters
//
// Build option
//   HAZARD_PERF_EN  when defined, stall_cnt / flush_cnt are saturating
//                   counters of stall_d / flush_d cycles; otherwise they
//                   are tied to 0 and no counter flops exist.
//
// State | meaning
// IDLE  | no hazard in progress; evaluate inputs fresh
// LOAD  | load-use stall in progress, cnt cycles left
// MULT  | waiting for the multiplier to become ready
// CTRL  | decode flush after a control transfer, cnt cycles left
module hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_to_reg_e,
  input  logic [REG_AW-1:0] reg_dst_e,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              rs_used_d,
  input  logic              rt_used_d,
  input  logic              start_mult,
  input  logic              mult_ready,
  input  logic              bt_flush,
  input  logic              j_flush,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              flush_d,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] MULT = 2'd2;
  localparam logic [1:0] CTRL = 2'd3;

  localparam logic [2:0] LOAD_INIT  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_LEN - 1);

  logic [1:0] state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       load_hz, ctrl;
  logic       stall, flush_e_raw, flush_d_raw;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_hz = mem_to_reg_e && (reg_dst_e != '0) &&
                   ((rs_used_d && (rs_d == reg_dst_e)) ||
                    (rt_used_d && (rt_d == reg_dst_e)));
  assign ctrl = bt_flush | j_flush;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall       = 1'b0;
    flush_e_raw = 1'b0;
    flush_d_raw = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (ctrl) begin
          // A control transfer overrides any pending load stall.
          flush_d_raw = 1'b1;
          flush_e_raw = 1'b1;
          if (FLUSH_LEN > 1) begin
            state_n = CTRL;
            cnt_n   = FLUSH_INIT;
          end else begin
            state_n = IDLE;
            cnt_n   = 3'd0;
          end
        end else if (state == LOAD) begin
          stall       = 1'b1;
          flush_e_raw = 1'b1;
          if (cnt == 3'd1) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
          end else begin
            cnt_n = cnt - 3'd1;
          end
        end else if (load_hz) begin
          stall       = 1'b1;
          flush_e_raw = 1'b1;
          if (LOAD_LAT > 1) begin
            state_n = LOAD;
            cnt_n   = LOAD_INIT;
          end
        end else if (start_mult) begin
          stall       = 1'b1;
          flush_e_raw = 1'b1;
          state_n     = MULT;
        end
      end
      MULT: begin
        // Control transfers cannot resolve while the pipeline is frozen.
        if (!mult_ready) begin
          stall       = 1'b1;
          flush_e_raw = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CTRL: begin
        flush_d_raw = 1'b1;
        if (ctrl) begin
          cnt_n = FLUSH_INIT;
        end else if (cnt == 3'd1) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign stall_f = reset & stall;
  assign stall_d = reset & stall;
  assign flush_e = reset & flush_e_raw;
  assign flush_d = reset & flush_d_raw;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_d && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share the stimulus:
//   u_a: LOAD_LAT=2, FLUSH_LEN=3, CNT_W=32
//   u_b: LOAD_LAT=3, FLUSH_LEN=1, CNT_W=3 (counter saturation at 7)
// Output vectors are {stall_f, stall_d, flush_e, flush_d}.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_to_reg_e;
  logic [4:0] reg_dst_e, rs_d, rt_d;
  logic       rs_used_d, rt_used_d, start_mult, mult_ready, bt_flush, j_flush;

  logic        a_stall_f, a_stall_d, a_flush_e, a_flush_d;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_stall_f, b_stall_d, b_flush_e, b_flush_d;
  logic [2:0]  b_stall_cnt, b_flush_cnt;
  logic [3:0]  a_o, b_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign a_o = {a_stall_f, a_stall_d, a_flush_e, a_flush_d};
  assign b_o = {b_stall_f, b_stall_d, b_flush_e, b_flush_d};

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .FLUSH_LEN(3), .CNT_W(32)) u_a (
    .clk(clk), .reset(reset), .mem_to_reg_e(mem_to_reg_e), .reg_dst_e(reg_dst_e),
    .rs_d(rs_d), .rt_d(rt_d), .rs_used_d(rs_used_d), .rt_used_d(rt_used_d),
    .start_mult(start_mult), .mult_ready(mult_ready), .bt_flush(bt_flush), .j_flush(j_flush),
    .stall_f(a_stall_f), .stall_d(a_stall_d), .flush_e(a_flush_e), .flush_d(a_flush_d),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_LEN(1), .CNT_W(3)) u_b (
    .clk(clk), .reset(reset), .mem_to_reg_e(mem_to_reg_e), .reg_dst_e(reg_dst_e),
    .rs_d(rs_d), .rt_d(rt_d), .rs_used_d(rs_used_d), .rt_used_d(rt_used_d),
    .start_mult(start_mult), .mult_ready(mult_ready), .bt_flush(bt_flush), .j_flush(j_flush),
    .stall_f(b_stall_f), .stall_d(b_stall_d), .flush_e(b_flush_e), .flush_d(b_flush_d),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  // Drive one cycle of inputs just after the falling edge; outputs settle #1 later.
  task automatic cyc(input logic m2r, input logic [4:0] dst, input logic [4:0] rs,
                     input logic [4:0] rt, input logic rsu, input logic rtu,
                     input logic sm, input logic mr, input logic bt, input logic j);
    @(negedge clk);
    mem_to_reg_e = m2r; reg_dst_e = dst; rs_d = rs; rt_d = rt;
    rs_used_d = rsu; rt_used_d = rtu; start_mult = sm; mult_ready = mr;
    bt_flush = bt; j_flush = j;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_to_reg_e = 1'b0; reg_dst_e = '0; rs_d = '0; rt_d = '0;
    rs_used_d = 1'b0; rt_used_d = 1'b0; start_mult = 1'b0; mult_ready = 1'b1;
    bt_flush = 1'b0; j_flush = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    idle_cyc();
    n_checks++; if (a_o !== 4'b0000) $display("FAIL reset_a_outs got %b want 0000", a_o); else n_pass++;
    n_checks++; if (a_stall_cnt !== 32'd0 || a_flush_cnt !== 32'd0)
      $display("FAIL reset_a_cnts got %0d/%0d want 0/0", a_stall_cnt, a_flush_cnt); else n_pass++;
    // Outputs are forced low while reset is held, even with a hazard present.
    @(negedge clk);
    reset = 1'b0; start_mult = 1'b1; mult_ready = 1'b0; j_flush = 1'b1;
    #1;
    n_checks++; if (a_o !== 4'b0000 || b_o !== 4'b0000)
      $display("FAIL reset_forced got a=%b b=%b want 0000", a_o, b_o); else n_pass++;
    apply_reset();
  endtask

  task automatic test_load();
    apply_reset();
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b1110) $display("FAIL load_c0_a got %b want 1110", a_o); else n_pass++;
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b1110) $display("FAIL load_c1_a got %b want 1110", a_o); else n_pass++;
    idle_cyc();
    n_checks++; if (a_o !== 4'b0000) $display("FAIL load_c2_a got %b want 0000", a_o); else n_pass++;
    n_checks++; if (b_o !== 4'b1110) $display("FAIL load_c2_b got %b want 1110", b_o); else n_pass++;
    idle_cyc();
    n_checks++; if (b_o !== 4'b0000) $display("FAIL load_c3_b got %b want 0000", b_o); else n_pass++;
    n_checks++; if (a_stall_cnt !== (PERF ? 32'd2 : 32'd0))
      $display("FAIL load_a_stall_cnt got %0d want %0d", a_stall_cnt, PERF ? 2 : 0); else n_pass++;
    n_checks++; if (b_stall_cnt !== (PERF ? 3'd3 : 3'd0))
      $display("FAIL load_b_stall_cnt got %0d want %0d", b_stall_cnt, PERF ? 3 : 0); else n_pass++;
  endtask

  task automatic test_no_hazard();
    apply_reset();
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b0000 || b_o !== 4'b0000)
      $display("FAIL nohz_r0 got a=%b b=%b want 0000", a_o, b_o); else n_pass++;
    cyc(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b0000) $display("FAIL nohz_rt_unused got %b want 0000", a_o); else n_pass++;
    cyc(1'b0, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b0000) $display("FAIL nohz_not_load got %b want 0000", a_o); else n_pass++;
    cyc(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b1110) $display("FAIL hz_rt_used got %b want 1110", a_o); else n_pass++;
  endtask

  task automatic test_mult();
    apply_reset();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b1110) $display("FAIL mult_start got %b want 1110", a_o); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      // A branch resolving while the multiplier is busy must be ignored.
      cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, (i == 2), 1'b0);
      n_checks++; if (a_o !== 4'b1110) $display("FAIL mult_wait%0d got %b want 1110", i, a_o); else n_pass++;
    end
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b0000) $display("FAIL mult_ready got %b want 0000", a_o); else n_pass++;
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b1110) $display("FAIL mult_b2b_start got %b want 1110", a_o); else n_pass++;
    idle_cyc();
    n_checks++; if (a_o !== 4'b0000) $display("FAIL mult_b2b_done got %b want 0000", a_o); else n_pass++;
    idle_cyc();
    n_checks++; if (a_stall_cnt !== (PERF ? 32'd6 : 32'd0) || a_flush_cnt !== 32'd0)
      $display("FAIL mult_cnts got %0d/%0d want %0d/0", a_stall_cnt, a_flush_cnt, PERF ? 6 : 0); else n_pass++;
  endtask

  task automatic test_ctrl_flush();
    apply_reset();
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (a_o !== 4'b0011 || b_o !== 4'b0011)
      $display("FAIL ctrl_c0 got a=%b b=%b want 0011", a_o, b_o); else n_pass++;
    idle_cyc();
    n_checks++; if (a_o !== 4'b0001 || b_o !== 4'b0000)
      $display("FAIL ctrl_c1 got a=%b b=%b want 0001/0000", a_o, b_o); else n_pass++;
    cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (a_o !== 4'b0001) $display("FAIL ctrl_c2_ignore got %b want 0001", a_o); else n_pass++;
    idle_cyc();
    n_checks++; if (a_o !== 4'b0000) $display("FAIL ctrl_c3 got %b want 0000", a_o); else n_pass++;
    n_checks++; if (a_flush_cnt !== (PERF ? 32'd3 : 32'd0))
      $display("FAIL ctrl_a_flush_cnt got %0d want %0d", a_flush_cnt, PERF ? 3 : 0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (a_o !== 4'b0001 || b_o !== 4'b0011)
      $display("FAIL b2b_c1 got a=%b b=%b want 0001/0011", a_o, b_o); else n_pass++;
    idle_cyc();
    n_checks++; if (a_o !== 4'b0001) $display("FAIL b2b_c2 got %b want 0001", a_o); else n_pass++;
    idle_cyc();
    n_checks++; if (a_o !== 4'b0001) $display("FAIL b2b_c3 got %b want 0001", a_o); else n_pass++;
    idle_cyc();
    n_checks++; if (a_o !== 4'b0000) $display("FAIL b2b_c4 got %b want 0000", a_o); else n_pass++;
    n_checks++; if (a_flush_cnt !== (PERF ? 32'd4 : 32'd0) || b_flush_cnt !== (PERF ? 3'd2 : 3'd0))
      $display("FAIL b2b_flush_cnt got a=%0d b=%0d want %0d/%0d", a_flush_cnt, b_flush_cnt,
               PERF ? 4 : 0, PERF ? 2 : 0); else n_pass++;
  endtask

  task automatic test_load_ctrl();
    apply_reset();
    cyc(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (b_o !== 4'b1110) $display("FAIL ldctrl_c0_b got %b want 1110", b_o); else n_pass++;
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (b_o !== 4'b0011) $display("FAIL ldctrl_c1_b got %b want 0011", b_o); else n_pass++;
    idle_cyc();
    n_checks++; if (b_o !== 4'b0000 || a_o !== 4'b0001)
      $display("FAIL ldctrl_c2 got a=%b b=%b want 0001/0000", a_o, b_o); else n_pass++;
    n_checks++; if (b_stall_cnt !== (PERF ? 3'd1 : 3'd0) || b_flush_cnt !== (PERF ? 3'd1 : 3'd0))
      $display("FAIL ldctrl_b_cnts got %0d/%0d want %0d/%0d", b_stall_cnt, b_flush_cnt,
               PERF ? 1 : 0, PERF ? 1 : 0); else n_pass++;
  endtask

  task automatic test_reset_mid_mult();
    apply_reset();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (a_o !== 4'b0000) $display("FAIL rstmid_outs got %b want 0000", a_o); else n_pass++;
    n_checks++; if (a_stall_cnt !== (PERF ? 32'd5 : 32'd0))
      $display("FAIL rstmid_cnt_before got %0d want %0d", a_stall_cnt, PERF ? 5 : 0); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (a_o !== 4'b0000) $display("FAIL rstmid_idle got %b want 0000", a_o); else n_pass++;
    n_checks++; if (a_stall_cnt !== 32'd0)
      $display("FAIL rstmid_cnt_after got %0d want 0", a_stall_cnt); else n_pass++;
  endtask

  task automatic test_saturate();
    apply_reset();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc();
    n_checks++; if (a_stall_cnt !== (PERF ? 32'd9 : 32'd0))
      $display("FAIL sat_a_cnt got %0d want %0d", a_stall_cnt, PERF ? 9 : 0); else n_pass++;
    n_checks++; if (b_stall_cnt !== (PERF ? 3'd7 : 3'd0))
      $display("FAIL sat_b_cnt got %0d want %0d", b_stall_cnt, PERF ? 7 : 0); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    mem_to_reg_e = 1'b0; reg_dst_e = '0; rs_d = '0; rt_d = '0;
    rs_used_d = 1'b0; rt_used_d = 1'b0; start_mult = 1'b0; mult_ready = 1'b1;
    bt_flush = 1'b0; j_flush = 1'b0;
    test_reset();
    test_load();
    test_no_hazard();
    test_mult();
    test_ctrl_flush();
    test_back_to_back();
    test_load_ctrl();
    test_reset_mid_mult();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter LOAD_LAT, default 1, legal 1..7; stall cycles per load-use hazard.
REQ-003 Parameter FLUSH_LEN, default 1, legal 1..7; decode-flush cycles per control transfer.
REQ-004 Parameter CNT_W, default 32, width of the performance counters.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; asserted when 0 at a rising clk edge.
REQ-007 mem_to_reg_e  in  1  instruction in E is a load.
REQ-008 reg_dst_e  in  REG_AW  destination register of the instruction in E.
REQ-009 rs_d, rt_d  in  REG_AW each  source registers of the instruction in D.
REQ-010 rs_used_d, rt_used_d  in  1 each  the D instruction actually reads rs / rt.
REQ-011 start_mult  in  1  D issues a multicycle multiply this cycle.
REQ-012 mult_ready  in  1  multiplier idle / result available.
REQ-013 bt_flush, j_flush  in  1 each  taken branch / jump resolved this cycle.
REQ-014 stall_f, stall_d  out  1 each  hold PC / hold the D register.
REQ-015 flush_e  out  1  insert a bubble into E.
REQ-016 flush_d  out  1  squash the D register.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  performance counters (see Configuration).

Function
REQ-018 load_hz = mem_to_reg_e & (reg_dst_e != 0) & ((rs_used_d & rs_d == reg_dst_e) | (rt_used_d & rt_d == reg_dst_e)); register 0 never causes a hazard.
REQ-019 ctrl = bt_flush | j_flush.
REQ-020 FSM states: IDLE, LOAD, MULT, CTRL; 3-bit down-counter cnt.
REQ-021 Outputs are combinational from the state and current inputs (Mealy); a hazard is covered in the same cycle it is detected.
REQ-022 IDLE priority is ctrl > load_hz > start_mult.
REQ-023 IDLE with ctrl: flush_d=1, flush_e=1, no stall. Next state is CTRL with cnt=FLUSH_LEN-1 when FLUSH_LEN>1, otherwise IDLE.
REQ-024 IDLE with load_hz and no ctrl: stall_f=stall_d=flush_e=1. Next state is LOAD with cnt=LOAD_LAT-1 when LOAD_LAT>1, otherwise IDLE.
REQ-025 IDLE with start_mult only: stall_f=stall_d=flush_e=1, next state MULT, regardless of mult_ready.
REQ-026 LOAD: stall_f=stall_d=flush_e=1; cnt decrements each cycle; the cycle with cnt==1 is the last stall cycle, then IDLE. The total stall equals LOAD_LAT cycles.
REQ-027 LOAD with ctrl: ctrl wins; behave as REQ-023 from that cycle and abandon the remaining load stall.
REQ-028 MULT with mult_ready==0: stall_f=stall_d=flush_e=1; bt_flush/j_flush are ignored.
REQ-029 MULT with mult_ready==1: all outputs 0 and next state IDLE. The following cycle is evaluated fresh, so back-to-back multiplies re-enter MULT.
REQ-030 CTRL: flush_d=1, other outputs 0; cnt decrements; exit to IDLE after the cycle with cnt==1. A new ctrl restarts cnt at FLUSH_LEN-1.
REQ-031 CTRL ignores load_hz and start_mult, because the D instruction is being squashed.
REQ-032 stall_f always equals stall_d.

Reset
REQ-033 reset==0 at a rising edge sets state=IDLE, cnt=0 and both perf counters to 0.
REQ-034 While reset==0, stall_f, stall_d, flush_e and flush_d are forced to 0 combinationally.
REQ-035 Reset mid-LOAD, mid-MULT or mid-CTRL aborts the operation; the first cycle after reset is in IDLE.

Configuration
REQ-036 With macro HAZARD_PERF_EN defined:
- stall_cnt increments by 1 on each rising edge where stall_d==1 and reset==1.
- flush_cnt increments by 1 on each rising edge where flush_d==1 and reset==1.
- Both counters saturate at 2^CNT_W-1.
REQ-037 With HAZARD_PERF_EN undefined: stall_cnt and flush_cnt are tied to 0, no counter flops exist, and FSM behaviour is identical.

Verification
REQ-038 LOAD_LAT=2, mem_to_reg_e=1, reg_dst_e=5, rs_d=5, rs_used_d=1 -> stall_d=flush_e=1 for exactly 2 cycles, then 0.
REQ-039 reg_dst_e=0=rs_d with load, or rt_d match with rt_used_d=0 -> no stall.
REQ-040 start_mult=1, mult_ready=0 for 4 cycles, then 1 -> stall_d high on the start cycle plus 4 MULT cycles, low on the ready cycle.
REQ-041 FLUSH_LEN=3, j_flush pulse -> flush_d high 3 cycles; simultaneous load_hz that cycle -> no stall.
REQ-042 LOAD_LAT=3, bt_flush on the 2nd stall cycle -> stall drops that cycle, flush_d=1.
REQ-043 reset=0 mid-MULT -> outputs 0 immediately and IDLE next cycle; with HAZARD_PERF_EN, 5 stall cycles -> stall_cnt=5 and reset clears it to 0.
